// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: blank pattern, segment type and hex-to-segment decode.
// Segment bit order is {g,f,e,d,c,b,a}; hex_to_seg returns active-high segments.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG7_OFF = 7'h7F;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;  // lowercase b
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;  // lowercase d
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high segment decoder, shared by all digits of
// the scan controller since only one digit is driven at a time.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with frame-synchronous shadow update,
// ghost blanking and leading-zero suppression. Define SEG7_DIM_EN to add the 4-bit brightness input.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DWELL_CYCLES = 1351,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   dig_en,
    input  logic                  lzb_en,
`ifdef SEG7_DIM_EN
    input  logic [3:0]            bright,
`endif
    output logic [N_DIGITS-1:0]   anode,
    output logic [6:0]            seven,
    output logic                  dp,
    output logic                  frame_pulse,
    output logic                  busy
);

    localparam int IW = ($clog2(N_DIGITS) > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PW = $clog2(DWELL_CYCLES);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    slot_end, wrap;

    logic [4*N_DIGITS-1:0]   pend_val_q, act_val_q;
    logic [N_DIGITS-1:0]     pend_dp_q, act_dp_q;
    logic [N_DIGITS-1:0]     pend_en_q, act_en_q;
    logic                    pend_lzb_q, act_lzb_q;
    logic                    busy_q, busy_d;
    logic                    frame_q;
`ifdef SEG7_DIM_EN
    logic [3:0]              pend_bright_q, act_bright_q;
`endif

    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_en, cur_lz;
    logic [N_DIGITS-1:0]     lz_mask;
    logic                    upper_zero;
    logic                    duty_on;
    logic                    dark;
    seg_t                    cur_seg;

    logic [N_DIGITS-1:0]     anode_q, anode_d;
    seg_t                    seven_q, seven_d;
    logic                    dp_q, dp_d;

    // Scan timing: prescaler per slot, digit index per frame; both wrap explicitly.
    always_comb begin
        slot_end = (presc_q == PRESC_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);
        presc_d  = slot_end ? '0 : presc_q + PW'(1);
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // A load coinciding with the wrap still lands in pending and keeps busy set.
    assign busy_d = load | (busy_q & ~wrap);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            pend_lzb_q    <= 1'b0;
            act_val_q     <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            act_lzb_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_q       <= 1'b0;
`ifdef SEG7_DIM_EN
            pend_bright_q <= '0;
            act_bright_q  <= '0;
`endif
        end else begin
            if (load) begin
                pend_val_q    <= value;
                pend_dp_q     <= dp_in;
                pend_en_q     <= dig_en;
                pend_lzb_q    <= lzb_en;
`ifdef SEG7_DIM_EN
                pend_bright_q <= bright;
`endif
            end
            if (wrap && busy_q) begin
                act_val_q     <= pend_val_q;
                act_dp_q      <= pend_dp_q;
                act_en_q      <= pend_en_q;
                act_lzb_q     <= pend_lzb_q;
`ifdef SEG7_DIM_EN
                act_bright_q  <= pend_bright_q;
`endif
            end
            busy_q  <= busy_d;
            frame_q <= wrap;
        end
    end

    // lz_mask[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (act_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
        lz_mask[0] = 1'b0;
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib = act_val_q[4*i +: 4];
                cur_dp  = act_dp_q[i];
                cur_en  = act_en_q[i];
                cur_lz  = lz_mask[i];
            end
        end
    end

    seg7_hex_decode u_decode (
        .nib_i (cur_nib),
        .seg_o (cur_seg)
    );

`ifdef SEG7_DIM_EN
    logic [PW-1:0] lit_phase;
    assign lit_phase = presc_q - BLANK_END;
    assign duty_on   = (lit_phase[3:0] < act_bright_q);
`else
    assign duty_on   = 1'b1;
`endif

    always_comb begin
        dark    = ~cur_en | (act_lzb_q & cur_lz);
        anode_d = '1;
        seven_d = SEG7_OFF;
        dp_d    = 1'b1;
        if (presc_q >= BLANK_END) begin
            seven_d = ~cur_seg;
            dp_d    = ~cur_dp;
            if (!dark && duty_on) begin
                anode_d = ~(N_DIGITS'(1) << idx_q);
            end
        end
    end

    // Output stage: one cycle behind the prescaler/index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_q <= '1;
            seven_q <= SEG7_OFF;
            dp_q    <= 1'b1;
        end else begin
            anode_q <= anode_d;
            seven_q <= seven_d;
            dp_q    <= dp_d;
        end
    end

    assign anode       = anode_q;
    assign seven       = seven_q;
    assign dp          = dp_q;
    assign frame_pulse = frame_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (N_DIGITS=4, DWELL_CYCLES=20, BLANK_CYCLES=4),
// with a frame-level reference model; connects bright when SEG7_DIM_EN is defined.
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int DW    = 20;
    localparam int BL    = 4;
    localparam int FRAME = ND * DW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  dig_en = '0;
    logic        lzb_en = 1'b0;
    logic [3:0]  bright_r = '0;
    logic [3:0]  anode;
    logic [6:0]  seven;
    logic        dp;
    logic        frame_pulse;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int unsigned st = 0;

    typedef struct {
        int unsigned k;
        int unsigned fr;
        logic [15:0] val;
        logic [3:0]  dpv;
        logic [3:0]  en;
        logic        lzb;
        logic [3:0]  br;
    } ld_t;

    ld_t q[$];
    ld_t act;

    logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_ctrl #(
        .N_DIGITS     (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .dig_en      (dig_en),
        .lzb_en      (lzb_en),
`ifdef SEG7_DIM_EN
        .bright      (bright_r),
`endif
        .anode       (anode),
        .seven       (seven),
        .dp          (dp),
        .frame_pulse (frame_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) st <= 0;
        else      st <= st + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s state=%0d got=%h want=%h", name, st, got, exp);
        end
    endtask

    // Expected {anode, seven, dp} for scan position k under display configuration c.
    function automatic logic [11:0] model_out(input ld_t c, input int unsigned k);
        int p;
        int i;
        logic [3:0] nib;
        logic [3:0] an;
        logic lit;
        p = int'(k % DW);
        i = int'((k / DW) % ND);
        if (p < BL) return {4'hF, 7'h7F, 1'b1};
        nib = 4'((c.val >> (4 * i)) & 16'hF);
        lit = c.en[i] && !(c.lzb && i != 0 && (c.val >> (4 * i)) == 16'h0);
`ifdef SEG7_DIM_EN
        lit = lit && (((p - BL) % 16) < int'(c.br));
`endif
        an = lit ? ~(4'b0001 << i) : 4'hF;
        return {an, ~SEG[nib], ~c.dpv[i]};
    endfunction

    // Monitor: pops applied loads at frame boundaries and checks every display cycle.
    always @(negedge clk) begin : monitor
        int unsigned j;
        int unsigned m;
        logic [11:0] e;
        logic b;
        if (rst) begin
            j = st;
            if (j == 0) begin
                e = {4'hF, 7'h7F, 1'b1};
            end else begin
                m = j - 1;
                while (q.size() > 0 && q[0].fr * FRAME <= m) act = q.pop_front();
                e = model_out(act, m);
            end
            b = 1'b0;
            foreach (q[x]) if (q[x].k < j && q[x].fr * FRAME > j) b = 1'b1;
            chk("anode", 32'(anode), 32'(e[11:8]));
            chk("seven", 32'(seven), 32'(e[7:1]));
            chk("dp", 32'(dp), 32'(e[0]));
            chk("frame_pulse", 32'(frame_pulse), 32'(j > 0 && j % FRAME == 0));
            chk("busy", 32'(busy), 32'(b));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        act = '{k: 0, fr: 0, val: '0, dpv: '0, en: '0, lzb: 1'b0, br: '0};
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                           input logic l, input logic [3:0] b);
        ld_t x;
        value = v; dp_in = d; dig_en = e; lzb_en = l; bright_r = b; load = 1'b1;
        x.k   = st;
        x.fr  = st / FRAME + 1 + ((st % FRAME == FRAME - 1) ? 1 : 0);
        x.val = v; x.dpv = d; x.en = e; x.lzb = l; x.br = b;
        q.push_back(x);
        cyc(1);
        load = 1'b0;
        value = 16'($urandom); dp_in = 4'($urandom); dig_en = 4'($urandom);
        lzb_en = 1'($urandom); bright_r = 4'($urandom);
    endtask

    task automatic wait_phase(input int ph);
        int guard;
        guard = 0;
        while (st % FRAME != ph && guard < 2 * FRAME) begin
            cyc(1);
            guard++;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [15:0] mask;
        model_reset();
        #2 rst = 1'b0;
        cyc(3);
        rst = 1'b1;

        // Full hex word, all digits enabled
        cyc(7);
        do_load(16'h12AF, 4'h0, 4'hF, 1'b0, 4'd15);
        cyc(2 * FRAME);

        // Leading-zero blanking
        do_load(16'h0050, 4'h0, 4'hF, 1'b1, 4'd15);
        cyc(2 * FRAME);
        do_load(16'h0000, 4'h0, 4'hF, 1'b1, 4'd15);
        cyc(2 * FRAME);

        // Two loads in one frame, then a load on the wrap cycle
        wait_phase(10);
        do_load(16'hDEAD, 4'h1, 4'hF, 1'b0, 4'd15);
        cyc(15);
        do_load(16'hBC98, 4'h8, 4'hF, 1'b0, 4'd15);
        cyc(FRAME);
        wait_phase(FRAME - 1);
        do_load(16'h3467, 4'h2, 4'hF, 1'b0, 4'd15);
        cyc(2 * FRAME);

        // Decimal point on a disabled digit
        do_load(16'h8888, 4'b0100, 4'b1011, 1'b0, 4'd15);
        cyc(2 * FRAME);

        // Dimming patterns (no effect on anode timing without SEG7_DIM_EN)
        do_load(16'hFFFF, 4'hF, 4'hF, 1'b0, 4'd4);
        cyc(2 * FRAME);
        do_load(16'h1234, 4'h0, 4'hF, 1'b0, 4'd0);
        cyc(2 * FRAME);

        // Asynchronous reset mid-scan with an update pending
        do_load(16'h5A5A, 4'hF, 4'hF, 1'b0, 4'd9);
        wait_phase(DW + 10);
        #2 rst = 1'b0;
        #1;
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_seven", 32'(seven), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_frame_pulse", 32'(frame_pulse), 32'h0);
        model_reset();
        cyc(2);
        rst = 1'b1;
        cyc(2 * FRAME);

        // Randomized loads at random spacing
        for (int n = 0; n < 40; n++) begin
            cyc($urandom_range(1, 120));
            case ($urandom_range(0, 3))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h00FF;
                2:       mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            do_load(16'($urandom) & mask, 4'($urandom), 4'($urandom), 1'($urandom),
                    4'($urandom));
        end
        cyc(3 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
